cardinal_input_port: RTL and testbench

// - Router-side receiver of one 64-bit link (NIC net_so/net_ri/net_do or a neighbour router output).
// - Holds one packet per virtual channel (even VC0 / odd VC1) in two single-entry slots.
// - Computes the XY route from the header and requests one of 5 switch outputs.
// - Presents the hop-decremented packet to the crossbar and releases the slot on grant.
// - One instance per router input direction (N, S, E, W, PE).

---
 rtl/cardinal_input_port_pkg.sv | 25 ++
 rtl/cardinal_input_port_vc_slot.sv | 27 ++
 rtl/cardinal_input_port.sv | 97 +++++++++
 tb/tb_cardinal_input_port.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cardinal_input_port_pkg.sv
// Shared constants for the cardinal router input port: header bit positions
// (bit 0 is the packet MSB), field widths and one-hot output directions.
package cardinal_input_port_pkg;

  localparam int PKT_W       = 64;
  localparam int HOP_FIELD_W = 8;

  localparam int VC_BIT   = 0;
  localparam int DX_BIT   = 1;
  localparam int DY_BIT   = 2;
  localparam int HOPX_POS = 8;
  localparam int HOPY_POS = 16;

  // Request vectors are indexed [0:4] = N, S, E, W, PE
  localparam logic [0:4] DIR_N  = 5'b10000;
  localparam logic [0:4] DIR_S  = 5'b01000;
  localparam logic [0:4] DIR_E  = 5'b00100;
  localparam logic [0:4] DIR_W  = 5'b00010;
  localparam logic [0:4] DIR_PE = 5'b00001;

  function automatic logic [HOP_FIELD_W-1:0] hop_dec(input logic [HOP_FIELD_W-1:0] h);
    return (h == '0) ? h : h - HOP_FIELD_W'(1);
  endfunction

endpackage

// File: rtl/cardinal_input_port_vc_slot.sv
// Single-entry packet holding register for one virtual channel.
// A write takes priority over a clear; reset empties the slot immediately.
module cardinal_input_port_vc_slot #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              clr,
  input  logic [0:DATA_W-1] d,
  output logic [0:DATA_W-1] q,
  output logic              full
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q    <= '0;
      full <= 1'b0;
    end else if (we) begin
      q    <= d;
      full <= 1'b1;
    end else if (clr) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/cardinal_input_port.sv
// Router input port: two VC slots, XY route computation with hop decrement,
// and slot release on switch grant. Polarity picks which slot receives and which sends.
module cardinal_input_port
  import cardinal_input_port_pkg::*;
#(
  parameter int DATA_W = PKT_W,
  parameter int HOP_W  = HOP_FIELD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              polarity,
  input  logic              in_si,
  output logic              in_ri,
  input  logic [0:DATA_W-1] in_di,
  output logic [0:4]        req,
  input  logic              gnt,
  output logic [0:DATA_W-1] out_do,
  output logic [1:0]        vc_full,
  output logic              err
);

  logic              rx_vc;
  logic              tx_vc;
  logic              accept;
  logic [1:0]        we;
  logic [1:0]        clr;
  logic [1:0]        full;
  logic [0:DATA_W-1] slot_q [2];
  logic [0:DATA_W-1] send_q;
  logic              send_full;
  logic [HOP_W-1:0]  hopx;
  logic [HOP_W-1:0]  hopy;

  assign rx_vc     = ~polarity;
  assign tx_vc     = polarity;
  assign in_ri     = reset & ~full[rx_vc];
  assign accept    = in_si & in_ri;
  assign send_q    = slot_q[tx_vc];
  assign send_full = full[tx_vc];
  assign vc_full   = full;
  assign hopx      = send_q[HOPX_POS +: HOP_W];
  assign hopy      = send_q[HOPY_POS +: HOP_W];

  always_comb begin
    we         = '0;
    clr        = '0;
    we[rx_vc]  = accept;
    clr[tx_vc] = gnt & (req != '0);
  end

  cardinal_input_port_vc_slot #(.DATA_W(DATA_W)) u_slot_vc0 (
    .clk   (clk),
    .reset (reset),
    .we    (we[0]),
    .clr   (clr[0]),
    .d     (in_di),
    .q     (slot_q[0]),
    .full  (full[0])
  );

  cardinal_input_port_vc_slot #(.DATA_W(DATA_W)) u_slot_vc1 (
    .clk   (clk),
    .reset (reset),
    .we    (we[1]),
    .clr   (clr[1]),
    .d     (in_di),
    .q     (slot_q[1]),
    .full  (full[1])
  );

  // X is exhausted first, then Y; a packet with no hops left is for the local PE
  always_comb begin
    req    = '0;
    out_do = '0;
    if (send_full) begin
      out_do = send_q;
      if (hopx != '0) begin
        req                         = send_q[DX_BIT] ? DIR_W : DIR_E;
        out_do[HOPX_POS +: HOP_W]   = hop_dec(hopx);
      end else if (hopy != '0) begin
        req                         = send_q[DY_BIT] ? DIR_S : DIR_N;
        out_do[HOPY_POS +: HOP_W]   = hop_dec(hopy);
      end else begin
        req                         = DIR_PE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else if (accept && (in_di[VC_BIT] != rx_vc)) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cardinal_input_port.sv
// Self-checking bench for cardinal_input_port: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a slot model.
module tb_cardinal_input_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        polarity;
  logic        in_si;
  logic        in_ri;
  logic [0:63] in_di;
  logic [0:4]  req;
  logic        gnt;
  logic [0:63] out_do;
  logic [1:0]  vc_full;
  logic        err;

  int checkCount = 0;
  int passCount  = 0;
  bit checkEn    = 1'b0;

  logic [0:63] mSlot [2];
  bit          mFull [2];
  bit          mErr;

  cardinal_input_port dut (
    .clk      (clk),
    .reset    (reset),
    .polarity (polarity),
    .in_si    (in_si),
    .in_ri    (in_ri),
    .in_di    (in_di),
    .req      (req),
    .gnt      (gnt),
    .out_do   (out_do),
    .vc_full  (vc_full),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  function automatic logic [0:63] mkPkt(input logic vc, input logic dx, input logic dy,
                                        input logic [7:0] hx, input logic [7:0] hy,
                                        input logic [31:0] pay);
    logic [0:63] p;
    p        = '0;
    p[0]     = vc;
    p[1]     = dx;
    p[2]     = dy;
    p[3:7]   = 5'b10101;
    p[8:15]  = hx;
    p[16:23] = hy;
    p[24:31] = 8'h5A;
    p[32:63] = pay;
    return p;
  endfunction

  // Reference routing: spend X hops first, then Y hops, else deliver locally
  function automatic void modelRoute(input logic [0:63] pkt, output logic [0:4] r,
                                     output logic [0:63] o);
    int hx;
    int hy;
    int dir;
    hx = int'(pkt[8:15]);
    hy = int'(pkt[16:23]);
    o  = pkt;
    if (hx > 0) begin
      dir      = pkt[1] ? 3 : 2;
      o[8:15]  = 8'(hx - 1);
    end else if (hy > 0) begin
      dir      = pkt[2] ? 1 : 0;
      o[16:23] = 8'(hy - 1);
    end else begin
      dir      = 4;
    end
    r      = '0;
    r[dir] = 1'b1;
  endfunction

  always @(posedge clk or negedge reset) begin : modelUpdate
    logic p;
    if (!reset) begin
      mFull[0] = 1'b0;
      mFull[1] = 1'b0;
      mErr     = 1'b0;
    end else begin
      p = polarity;
      if (in_si && !mFull[!p]) begin
        mSlot[!p] = in_di;
        mFull[!p] = 1'b1;
        if (in_di[0] != !p) mErr = 1'b1;
      end
      if (gnt && mFull[p]) mFull[p] = 1'b0;
    end
  end

  always @(negedge clk) begin : compare
    logic [0:4]  eReq;
    logic [0:63] eOut;
    if (checkEn) begin
      eReq = '0;
      eOut = '0;
      if (reset && mFull[polarity]) modelRoute(mSlot[polarity], eReq, eOut);
      checkOutput("model_in_ri", in_ri, reset && !mFull[!polarity]);
      checkOutput("model_req", req, eReq);
      checkOutput("model_out_do", out_do, eOut);
      checkOutput("model_vc_full", vc_full, reset ? {mFull[1], mFull[0]} : 2'b00);
      checkOutput("model_err", err, reset ? mErr : 1'b0);
    end
  end

  task automatic applyStimulus(input logic rst, input logic si, input logic [0:63] di, input logic g);
    @(posedge clk);
    #1;
    reset    = rst;
    polarity = ~polarity;
    in_si    = si;
    in_di    = di;
    gnt      = g;
  endtask

  task automatic alignTo(input logic p);
    if (polarity == p) applyStimulus(1'b1, 1'b0, '0, 1'b0);
  endtask

  initial begin
    logic [0:63] pA;
    logic [0:63] pB;
    logic [0:63] pC;
    logic [0:63] di;
    logic        rst;

    reset    = 1'b0;
    polarity = 1'b0;
    in_si    = 1'b1;
    in_di    = mkPkt(1'b1, 1'b0, 1'b0, 8'd1, 8'd1, 32'hDEAD_BEEF);
    gnt      = 1'b0;
    @(posedge clk);
    checkEn = 1'b1;
    repeat (3) applyStimulus(1'b0, 1'b1, in_di, 1'b0);
    @(negedge clk);
    checkOutput("reset_in_ri", in_ri, 1'b0);
    checkOutput("reset_req", req, 5'b00000);
    checkOutput("reset_vc_full", vc_full, 2'b00);

    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("release_in_ri", in_ri, 1'b1);

    // Accept at p=0 into VC1, route east next cycle
    pA = mkPkt(1'b1, 1'b0, 1'b0, 8'd3, 8'd2, 32'h1234_5678);
    alignTo(1'b0);
    applyStimulus(1'b1, 1'b1, pA, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("east_vc_full", vc_full, 2'b10);
    checkOutput("east_req", req, 5'b00100);
    checkOutput("east_out_do", out_do, mkPkt(1'b1, 1'b0, 1'b0, 8'd2, 8'd2, 32'h1234_5678));
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("east_released", vc_full, 2'b00);

    // Local delivery to PE
    pB = mkPkt(1'b1, 1'b1, 1'b1, 8'd0, 8'd0, 32'hCAFE_F00D);
    alignTo(1'b0);
    applyStimulus(1'b1, 1'b1, pB, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("pe_req", req, 5'b00001);
    checkOutput("pe_out_do", out_do, pB);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("pe_released", vc_full, 2'b00);

    // Backpressure: VC1 held, second packet refused, request repeated
    pA = mkPkt(1'b1, 1'b1, 1'b0, 8'd1, 8'd0, 32'h0000_0001);
    pC = mkPkt(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 32'h0000_0002);
    alignTo(1'b0);
    applyStimulus(1'b1, 1'b1, pA, 1'b0);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 1'b0, '0, 1'b0);
      @(negedge clk);
      checkOutput("bp_req", req, 5'b00010);
      checkOutput("bp_out_do", out_do, mkPkt(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 32'h0000_0001));
      applyStimulus(1'b1, 1'b1, pC, 1'b0);
      @(negedge clk);
      checkOutput("bp_in_ri", in_ri, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);

    // Concurrent grant of VC0 and accept into VC1
    pA = mkPkt(1'b0, 1'b0, 1'b0, 8'd0, 8'd4, 32'hAAAA_5555);
    pB = mkPkt(1'b1, 1'b0, 1'b1, 8'd0, 8'd1, 32'h5555_AAAA);
    alignTo(1'b1);
    applyStimulus(1'b1, 1'b1, pA, 1'b0);
    applyStimulus(1'b1, 1'b1, pB, 1'b1);
    @(negedge clk);
    checkOutput("conc_before", vc_full, 2'b01);
    checkOutput("conc_req_n", req, 5'b10000);
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("conc_after", vc_full, 2'b10);
    checkOutput("conc_req_s", req, 5'b01000);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);

    // VC mismatch: stored anyway, sticky err
    pA = mkPkt(1'b0, 1'b0, 1'b1, 8'd0, 8'd1, 32'h0BAD_0BAD);
    alignTo(1'b0);
    applyStimulus(1'b1, 1'b1, pA, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("vcm_err", err, 1'b1);
    checkOutput("vcm_vc_full", vc_full, 2'b10);
    checkOutput("vcm_req", req, 5'b01000);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("vcm_err_sticky", err, 1'b1);
    checkOutput("vcm_released", vc_full, 2'b00);

    // Randomized traffic, including mid-operation resets and extreme hop counts
    for (int c = 0; c < 3000; c++) begin
      di       = mkPkt(1'b0, 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 19) == 0) ? 8'hFF : 8'($urandom_range(0, 3)),
                       ($urandom_range(0, 19) == 0) ? 8'hFF : 8'($urandom_range(0, 3)),
                       $urandom);
      di[3:7]  = 5'($urandom);
      di[24:31] = 8'($urandom);
      // Next cycle's polarity is the inverse of the current one; its receive VC equals the current polarity
      di[0]    = ($urandom_range(0, 9) == 0) ? ~polarity : polarity;
      rst      = ($urandom_range(0, 99) != 0);
      applyStimulus(rst, 1'($urandom), di, 1'($urandom));
    end
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    #1;
    checkEn = 1'b0;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
